// File: rtl/bf_mem_arbiter_if.sv
// Shared memory port handshake between the bfX requesters and the memory arbiter.
// Requesters drive req/we; the arbiter returns mux selects, memory strobes, grant and ack.
interface bf_mem_arbiter_if;
  logic [3:0] req;
  logic [3:0] we;
  logic [1:0] addr_sel;
  logic       wdata_sel;
  logic       mem_en;
  logic       mem_we;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic       wr_err;
  logic       busy;

  modport master (
    output req, we,
    input  addr_sel, wdata_sel, mem_en, mem_we, gnt, ack, wr_err, busy
  );

  modport slave (
    input  req, we,
    output addr_sel, wdata_sel, mem_en, mem_we, gnt, ack, wr_err, busy
  );
endinterface

// File: rtl/bf_mem_arbiter.sv
// Arbiter for the single shared bfX memory port: picks a requester, strobes memory once,
// waits out the read latency and returns a one-cycle ack to the winner.
module bf_mem_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter bit DBG_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  bf_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // WAIT covers MEM_LAT-1 cycles; with MEM_LAT=1 it is skipped and the load is unused
  localparam logic [3:0] CNT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [1:0] rr_last_r;
  logic [1:0] addr_sel_r;
  logic       wdata_sel_r;
  logic       mem_en_r;
  logic       mem_we_r;
  logic [3:0] gnt_r;
  logic [3:0] ack_r;
  logic       wr_err_r;
  logic       busy_r;
  logic [1:0] win_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Debug override first, otherwise first set bit searching upward from last+1 (wraps to last)
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd3;
    found = DBG_PRIO & req[3];
    for (int i = 1; i <= 4; i++) begin
      idx   = last + 2'(i);
      win   = (!found && req[idx]) ? idx : win;
      found = found | req[idx];
    end
    return win;
  endfunction

  // Winner candidate for the current IDLE cycle
  always_comb begin
    win_s = pick_winner(bus.req, rr_last_r);
  end

  // Access sequencer with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rr_last_r   <= 2'd3;
      addr_sel_r  <= 2'd0;
      wdata_sel_r <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      gnt_r       <= 4'd0;
      ack_r       <= 4'd0;
      wr_err_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.req) begin
            state_r     <= GRANT;
            rr_last_r   <= win_s;
            gnt_r       <= onehot(win_s);
            addr_sel_r  <= win_s;
            wdata_sel_r <= (win_s == 2'd3);
            mem_en_r    <= 1'b1;
            // Only requesters 1 and 3 may write; 0 and 2 are demoted to a read
            mem_we_r    <= bus.we[win_s] & win_s[0];
            wr_err_r    <= bus.we[win_s] & ~win_s[0];
            busy_r      <= 1'b1;
          end else begin
            state_r  <= IDLE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            wr_err_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        GRANT: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          wr_err_r <= 1'b0;
          if (MEM_LAT == 1) begin
            state_r <= ACK;
            ack_r   <= gnt_r;
          end else begin
            state_r <= WAIT;
            cnt_r   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ACK;
            ack_r   <= gnt_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK: begin
          // No arbitration here so a stale req is never regranted
          state_r <= IDLE;
          gnt_r   <= 4'd0;
          ack_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= 4'd0;
          ack_r    <= 4'd0;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          wr_err_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_sel  = addr_sel_r;
  assign bus.wdata_sel = wdata_sel_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.gnt       = gnt_r;
  assign bus.ack       = ack_r;
  assign bus.wr_err    = wr_err_r;
  assign bus.busy      = busy_r;

endmodule
